// File: rtl/heichips25_mem_req_scheduler.sv
// Round-robin scheduler merging instruction-fetch and LSU requests onto one memory link,
// with an in-order tag FIFO that steers read responses back to their issuer.
module heichips25_mem_req_scheduler #(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned AddrWidth      = 8,
    parameter int unsigned DataWidth      = 32,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inst_valid_i,
    output logic                 inst_ready_o,
    input  logic [AddrWidth-1:0] inst_addr_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [AddrWidth-1:0] lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_data_i,
    input  logic [StrbWidth-1:0] lsu_strb_i,
    input  logic                 lsu_write_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [AddrWidth-1:0] req_addr_o,
    output logic [DataWidth-1:0] req_data_o,
    output logic [StrbWidth-1:0] req_strb_o,
    output logic                 req_write_o,
    output logic                 req_sel_o,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [DataWidth-1:0] rsp_data_i,
    output logic                 inst_rsp_valid_o,
    input  logic                 inst_rsp_ready_i,
    output logic [DataWidth-1:0] inst_rsp_data_o,
    output logic                 lsu_rsp_valid_o,
    input  logic                 lsu_rsp_ready_i,
    output logic [DataWidth-1:0] lsu_rsp_data_o,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 err_spurious_o
);
    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic                      prio_q, prio_d;
    logic                      lock_q, lock_d;
    logic                      lock_sel_q, lock_sel_d;
    logic [MaxOutstanding-1:0] tag_q, tag_d;
    logic [PtrWidth-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]       count_q, count_d;
    logic                      err_q, err_d;

    logic full, empty, inst_elig, lsu_elig, sel, req_valid, accept, push, pop, head;

    // Arbitration: a held lock wins; otherwise the pointer breaks ties between eligible requesters.
    always_comb begin
        full      = (count_q == CntWidth'(MaxOutstanding));
        empty     = (count_q == '0);
        inst_elig = inst_valid_i && !full;
        lsu_elig  = lsu_valid_i && (lsu_write_i || !full);
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (inst_elig && lsu_elig) begin
            sel = prio_q;
        end else begin
            sel = lsu_elig;
        end
        req_valid = lock_q || inst_elig || lsu_elig;
    end

    assign req_valid_o  = req_valid;
    assign req_sel_o    = sel;
    assign req_addr_o   = sel ? lsu_addr_i  : inst_addr_i;
    assign req_data_o   = sel ? lsu_data_i  : '0;
    assign req_strb_o   = sel ? lsu_strb_i  : '0;
    assign req_write_o  = sel ? lsu_write_i : 1'b0;
    assign inst_ready_o = req_valid && !sel && req_ready_i;
    assign lsu_ready_o  = req_valid && sel && req_ready_i;

    assign accept = req_valid && req_ready_i;
    assign push   = accept && !req_write_o;

    // With an empty tracker any response is accepted and dropped.
    assign head             = tag_q[rd_ptr_q];
    assign inst_rsp_valid_o = rsp_valid_i && !empty && !head;
    assign lsu_rsp_valid_o  = rsp_valid_i && !empty && head;
    assign inst_rsp_data_o  = rsp_data_i;
    assign lsu_rsp_data_o   = rsp_data_i;
    assign rsp_ready_o      = empty ? rsp_valid_i : (head ? lsu_rsp_ready_i : inst_rsp_ready_i);
    assign pop              = rsp_valid_i && rsp_ready_o && !empty;

    assign outstanding_o  = count_q;
    assign err_spurious_o = err_q;

    always_comb begin
        prio_d     = prio_q;
        lock_d     = req_valid && !req_ready_i;
        lock_sel_d = sel;
        tag_d      = tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q || (rsp_valid_i && empty);
        if (accept) begin
            prio_d = ~sel;
        end
        if (push) begin
            tag_d[wr_ptr_q] = sel;
            wr_ptr_d = (wr_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_heichips25_mem_req_scheduler.sv
// Directed bench for heichips25_mem_req_scheduler; a destination queue predicts where each
// read response must be steered.
module tb_heichips25_mem_req_scheduler;
    logic        clk;
    logic        rst_n;
    logic        inst_valid_i, inst_ready_o;
    logic [7:0]  inst_addr_i;
    logic        lsu_valid_i, lsu_ready_o;
    logic [7:0]  lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [3:0]  lsu_strb_i;
    logic        lsu_write_i;
    logic        req_valid_o, req_ready_i;
    logic [7:0]  req_addr_o;
    logic [31:0] req_data_o;
    logic [3:0]  req_strb_o;
    logic        req_write_o, req_sel_o;
    logic        rsp_valid_i, rsp_ready_o;
    logic [31:0] rsp_data_i;
    logic        inst_rsp_valid_o, inst_rsp_ready_i;
    logic [31:0] inst_rsp_data_o;
    logic        lsu_rsp_valid_o, lsu_rsp_ready_i;
    logic [31:0] lsu_rsp_data_o;
    logic [2:0]  outstanding_o;
    logic        err_spurious_o;

    heichips25_mem_req_scheduler #(
        .MaxOutstanding(4), .AddrWidth(8), .DataWidth(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o), .inst_addr_i(inst_addr_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_addr_i(lsu_addr_i),
        .lsu_data_i(lsu_data_i), .lsu_strb_i(lsu_strb_i), .lsu_write_i(lsu_write_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .req_data_o(req_data_o), .req_strb_o(req_strb_o), .req_write_o(req_write_o),
        .req_sel_o(req_sel_o),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_data_i(rsp_data_i),
        .inst_rsp_valid_o(inst_rsp_valid_o), .inst_rsp_ready_i(inst_rsp_ready_i),
        .inst_rsp_data_o(inst_rsp_data_o),
        .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_ready_i(lsu_rsp_ready_i),
        .lsu_rsp_data_o(lsu_rsp_data_o),
        .outstanding_o(outstanding_o), .err_spurious_o(err_spurious_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;
    logic [0:0] exp_q[$];   // expected destination of each in-flight read (0=fetch, 1=LSU)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Read accepted this cycle: update the model after the edge.
    task automatic accept_read(input logic dst);
        tick();
        exp_q.push_back(dst);
        model_cnt++;
        chk("outstanding_push", 32'(outstanding_o), 32'(model_cnt));
    endtask

    // Present one response with both targets ready and check its steering.
    task automatic drive_rsp(input logic [31:0] d);
        logic [0:0] dst;
        rsp_valid_i = 1'b1;
        rsp_data_i  = d;
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            dst = 1'b0;
        end else begin
            dst = exp_q.pop_front();
        end
        chk("rsp_inst_valid", 32'(inst_rsp_valid_o), 32'(!dst));
        chk("rsp_lsu_valid", 32'(lsu_rsp_valid_o), 32'(dst));
        chk("rsp_data", dst ? lsu_rsp_data_o : inst_rsp_data_o, d);
        chk("rsp_ready", 32'(rsp_ready_o), 32'd1);
        tick();
        rsp_valid_i = 1'b0;
        model_cnt--;
        chk("outstanding_pop", 32'(outstanding_o), 32'(model_cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        inst_valid_i = 0; inst_addr_i = 8'h10;
        lsu_valid_i = 0; lsu_addr_i = 8'h20; lsu_data_i = 0; lsu_strb_i = 0; lsu_write_i = 0;
        req_ready_i = 0; rsp_valid_i = 1'b1; rsp_data_i = 0;
        inst_rsp_ready_i = 1; lsu_rsp_ready_i = 1;
        #3;
        // Reset values
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_err", 32'(err_spurious_o), 32'd0);
        chk("rst_req_valid", 32'(req_valid_o), 32'd0);
        chk("rst_rsp_ready", 32'(rsp_ready_o), 32'd1);
        chk("rst_inst_rsp_valid", 32'(inst_rsp_valid_o), 32'd0);
        chk("rst_lsu_rsp_valid", 32'(lsu_rsp_valid_o), 32'd0);
        rsp_valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Both requesters contend: 0,1,0,1
        inst_valid_i = 1; lsu_valid_i = 1; req_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_sel", 32'(req_sel_o), 32'(k % 2));
            chk("rr_addr", 32'(req_addr_o), (k % 2) ? 32'h20 : 32'h10);
            chk("rr_inst_ready", 32'(inst_ready_o), 32'(k % 2 == 0));
            chk("rr_lsu_ready", 32'(lsu_ready_o), 32'(k % 2 == 1));
            accept_read(1'(k % 2));
        end

        // Full: LSU write issues, fetch read is held
        lsu_write_i = 1; lsu_data_i = 32'hCAFE_F00D; lsu_strb_i = 4'hA; lsu_addr_i = 8'h44;
        #1;
        chk("full_sel", 32'(req_sel_o), 32'd1);
        chk("full_write", 32'(req_write_o), 32'd1);
        chk("full_data", req_data_o, 32'hCAFE_F00D);
        chk("full_strb", 32'(req_strb_o), 32'hA);
        chk("full_inst_ready", 32'(inst_ready_o), 32'd0);
        chk("full_lsu_ready", 32'(lsu_ready_o), 32'd1);
        tick();
        chk("write_untracked", 32'(outstanding_o), 32'(model_cnt));
        lsu_valid_i = 0; lsu_write_i = 0;
        #1;
        chk("blocked_req_valid", 32'(req_valid_o), 32'd0);
        chk("blocked_inst_ready", 32'(inst_ready_o), 32'd0);
        drive_rsp(32'hD000_0000);
        #1;
        chk("unblock_req_valid", 32'(req_valid_o), 32'd1);
        chk("unblock_inst_ready", 32'(inst_ready_o), 32'd1);
        chk("unblock_data_zero", req_data_o, 32'd0);
        accept_read(1'b0);
        inst_valid_i = 0;
        for (int k = 0; k < 4; k++) drive_rsp($urandom);

        // Lock-in: fetch held by backpressure, LSU arrives in cycle 2
        inst_valid_i = 1; inst_addr_i = 8'h55; req_ready_i = 0;
        #1;
        chk("lock_c1_sel", 32'(req_sel_o), 32'd0);
        chk("lock_c1_valid", 32'(req_valid_o), 32'd1);
        tick();
        lsu_valid_i = 1; lsu_addr_i = 8'h66;
        #1;
        chk("lock_c2_sel", 32'(req_sel_o), 32'd0);
        chk("lock_c2_addr", 32'(req_addr_o), 32'h55);
        chk("lock_c2_lsu_ready", 32'(lsu_ready_o), 32'd0);
        tick();
        #1;
        chk("lock_c3_sel", 32'(req_sel_o), 32'd0);
        chk("lock_c3_addr", 32'(req_addr_o), 32'h55);
        tick();
        req_ready_i = 1;
        #1;
        chk("lock_acc_sel", 32'(req_sel_o), 32'd0);
        chk("lock_acc_inst_ready", 32'(inst_ready_o), 32'd1);
        accept_read(1'b0);
        inst_valid_i = 0;
        #1;
        chk("lock_next_sel", 32'(req_sel_o), 32'd1);
        chk("lock_next_addr", 32'(req_addr_o), 32'h66);
        accept_read(1'b1);
        lsu_valid_i = 0;

        // Ordering and backpressure: fetch, LSU, fetch in flight
        inst_valid_i = 1; inst_addr_i = 8'h30;
        accept_read(1'b0);
        inst_valid_i = 0;
        drive_rsp(32'hD0D0_D0D0);
        lsu_rsp_ready_i = 0; rsp_valid_i = 1; rsp_data_i = 32'hD1D1_D1D1;
        #1;
        chk("bp_lsu_valid", 32'(lsu_rsp_valid_o), 32'd1);
        chk("bp_inst_valid", 32'(inst_rsp_valid_o), 32'd0);
        chk("bp_rsp_ready", 32'(rsp_ready_o), 32'd0);
        tick();
        chk("bp_hold_count", 32'(outstanding_o), 32'(model_cnt));
        lsu_rsp_ready_i = 1;
        drive_rsp(32'hD1D1_D1D1);
        drive_rsp(32'hD2D2_D2D2);

        // Reset mid-operation with 3 reads outstanding and the pointer at LSU
        inst_valid_i = 1;
        for (int k = 0; k < 3; k++) accept_read(1'b0);
        lsu_valid_i = 1; req_ready_i = 0;
        #1;
        chk("pre_rst_sel", 32'(req_sel_o), 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("mid_rst_sel", 32'(req_sel_o), 32'd0);
        exp_q.delete();
        model_cnt = 0;
        tick();
        rst_n = 1;
        req_ready_i = 1;
        #1;
        chk("post_rst_sel", 32'(req_sel_o), 32'd0);
        chk("post_rst_inst_ready", 32'(inst_ready_o), 32'd1);
        accept_read(1'b0);
        #1;
        chk("post_rst_sel2", 32'(req_sel_o), 32'd1);
        accept_read(1'b1);
        inst_valid_i = 0; lsu_valid_i = 0;
        drive_rsp($urandom);
        drive_rsp($urandom);

        // Spurious response on an empty tracker
        rsp_valid_i = 1; rsp_data_i = 32'hBAD0_BAD0;
        #1;
        chk("spur_rsp_ready", 32'(rsp_ready_o), 32'd1);
        chk("spur_inst_valid", 32'(inst_rsp_valid_o), 32'd0);
        chk("spur_lsu_valid", 32'(lsu_rsp_valid_o), 32'd0);
        chk("spur_err_before", 32'(err_spurious_o), 32'd0);
        tick();
        rsp_valid_i = 0;
        chk("spur_err_set", 32'(err_spurious_o), 32'd1);
        chk("spur_count", 32'(outstanding_o), 32'd0);
        tick();
        tick();
        chk("spur_err_sticky", 32'(err_spurious_o), 32'd1);
        rst_n = 0;
        #1;
        chk("spur_err_cleared", 32'(err_spurious_o), 32'd0);
        tick();
        rst_n = 1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
